// File: rtl/cp0_tlb_pkg.sv
// rtl/cp0_tlb_pkg.sv - CP0 TLB register numbers, writable field masks and TLB op codes
package cp0_tlb_pkg;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_CONTEXT  = 5'd4;
  localparam logic [4:0] CP0_PAGEMASK = 5'd5;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

  localparam logic [31:0] MASK_ENTRYLO  = 32'h03FF_FFFF;
  localparam logic [31:0] MASK_PAGEMASK = 32'h01FF_E000;
  localparam logic [31:0] MASK_ENTRYHI  = 32'hFFFF_E0FF;
  localparam logic [31:0] MASK_PTEBASE  = 32'hFF80_0000;

  typedef enum logic [2:0] {
    TLB_OP_NONE  = 3'd0,
    TLB_OP_TLBP  = 3'd1,
    TLB_OP_TLBR  = 3'd2,
    TLB_OP_TLBWI = 3'd3,
    TLB_OP_TLBWR = 3'd4
  } tlb_op_e;

endpackage

// File: rtl/cp0_tlb_regs_random.sv
// rtl/cp0_tlb_regs_random.sv - Random register: free-running down-counter bounded below by Wired
module tlb_random_ctr
  import cp0_tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [$clog2(TLB_ENTRIES)-1:0] wired_i,
  input  logic                           wired_wr_i,
  output logic [$clog2(TLB_ENTRIES)-1:0] random_o
);

  localparam int IW = $clog2(TLB_ENTRIES);
  localparam logic [IW-1:0] TOP = IW'(TLB_ENTRIES - 1);

  logic [IW-1:0] random_q, random_d;

  // Reaching Wired wraps to the top; with Wired at the top this holds there.
  always_comb begin
    if (wired_wr_i || (random_q == wired_i)) random_d = TOP;
    else                                     random_d = random_q - IW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) random_q <= TOP;
    else       random_q <= random_d;
  end

  assign random_o = random_q;

endmodule

// File: rtl/cp0_tlb_regs.sv
// rtl/cp0_tlb_regs.sv - CP0 TLB register file between M-stage mtc0/mfc0 and the TLB
module cp0_tlb_regs
  import cp0_tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     tlb_typeM,
  input  logic                           mtc0_en,
  input  logic [4:0]                     mtc0_addr,
  input  logic [31:0]                    mtc0_data,
  input  logic [4:0]                     mfc0_addr,
  output logic [31:0]                    mfc0_data,
  input  logic                           tlbp_found,
  input  logic [$clog2(TLB_ENTRIES)-1:0] tlbp_index,
  input  logic [31:0]                    tlbr_EntryHi,
  input  logic [31:0]                    tlbr_PageMask,
  input  logic [31:0]                    tlbr_EntryLo0,
  input  logic [31:0]                    tlbr_EntryLo1,
  input  logic                           tlb_exc,
  input  logic [31:0]                    tlb_exc_vaddr,
  output logic [31:0]                    EntryHi_o,
  output logic [31:0]                    PageMask_o,
  output logic [31:0]                    EntryLo0_o,
  output logic [31:0]                    EntryLo1_o,
  output logic [31:0]                    Index_o,
  output logic [31:0]                    Random_o
);

  localparam int IW = $clog2(TLB_ENTRIES);

  logic          index_p_q, index_p_d;
  logic [IW-1:0] index_q, index_d;
  logic [IW-1:0] wired_q, wired_d;
  logic [IW-1:0] random;
  logic [31:0]   entrylo0_q, entrylo0_d, entrylo1_q, entrylo1_d;
  logic [31:0]   context_q, context_d, pagemask_q, pagemask_d;
  logic [31:0]   badvaddr_q, badvaddr_d, entryhi_q, entryhi_d;
  logic          wired_wr;

  assign wired_wr = mtc0_en && (mtc0_addr == CP0_WIRED);

  tlb_random_ctr #(.TLB_ENTRIES(TLB_ENTRIES)) u_random (
    .clk_i      (clk),
    .rst_i      (rst),
    .wired_i    (wired_q),
    .wired_wr_i (wired_wr),
    .random_o   (random)
  );

  // Later assignments win: mtc0, then TLBP/TLBR writeback, then exception capture.
  always_comb begin
    index_p_d  = index_p_q;
    index_d    = index_q;
    wired_d    = wired_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    context_d  = context_q;
    pagemask_d = pagemask_q;
    badvaddr_d = badvaddr_q;
    entryhi_d  = entryhi_q;
    if (mtc0_en) begin
      case (mtc0_addr)
        CP0_INDEX:    index_d    = mtc0_data[IW-1:0];
        CP0_ENTRYLO0: entrylo0_d = mtc0_data & MASK_ENTRYLO;
        CP0_ENTRYLO1: entrylo1_d = mtc0_data & MASK_ENTRYLO;
        CP0_CONTEXT:  context_d  = (mtc0_data & MASK_PTEBASE) | (context_q & ~MASK_PTEBASE);
        CP0_PAGEMASK: pagemask_d = mtc0_data & MASK_PAGEMASK;
        CP0_WIRED:    wired_d    = mtc0_data[IW-1:0];
        CP0_ENTRYHI:  entryhi_d  = mtc0_data & MASK_ENTRYHI;
        default: ;
      endcase
    end
    if (tlb_typeM == TLB_OP_TLBP) begin
      index_p_d = ~tlbp_found;
      index_d   = tlbp_found ? tlbp_index : '0;
    end
    if (tlb_typeM == TLB_OP_TLBR) begin
      entryhi_d  = tlbr_EntryHi  & MASK_ENTRYHI;
      pagemask_d = tlbr_PageMask & MASK_PAGEMASK;
      entrylo0_d = tlbr_EntryLo0 & MASK_ENTRYLO;
      entrylo1_d = tlbr_EntryLo1 & MASK_ENTRYLO;
    end
    if (tlb_exc) begin
      badvaddr_d = tlb_exc_vaddr;
      entryhi_d  = {tlb_exc_vaddr[31:13], entryhi_q[12:0]};
      context_d  = {context_q[31:23], tlb_exc_vaddr[31:13], 4'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_p_q  <= 1'b0;
      index_q    <= '0;
      wired_q    <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      context_q  <= '0;
      pagemask_q <= '0;
      badvaddr_q <= '0;
      entryhi_q  <= '0;
    end else begin
      index_p_q  <= index_p_d;
      index_q    <= index_d;
      wired_q    <= wired_d;
      entrylo0_q <= entrylo0_d;
      entrylo1_q <= entrylo1_d;
      context_q  <= context_d;
      pagemask_q <= pagemask_d;
      badvaddr_q <= badvaddr_d;
      entryhi_q  <= entryhi_d;
    end
  end

  assign Index_o    = {index_p_q, {(31 - IW){1'b0}}, index_q};
  assign Random_o   = 32'(random);
  assign EntryHi_o  = entryhi_q;
  assign PageMask_o = pagemask_q;
  assign EntryLo0_o = entrylo0_q;
  assign EntryLo1_o = entrylo1_q;

  always_comb begin
    case (mfc0_addr)
      CP0_INDEX:    mfc0_data = Index_o;
      CP0_RANDOM:   mfc0_data = Random_o;
      CP0_ENTRYLO0: mfc0_data = entrylo0_q;
      CP0_ENTRYLO1: mfc0_data = entrylo1_q;
      CP0_CONTEXT:  mfc0_data = context_q;
      CP0_PAGEMASK: mfc0_data = pagemask_q;
      CP0_WIRED:    mfc0_data = 32'(wired_q);
      CP0_BADVADDR: mfc0_data = badvaddr_q;
      CP0_ENTRYHI:  mfc0_data = entryhi_q;
      default:      mfc0_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// tb/tb_cp0_tlb_regs.sv - directed self-checking bench for cp0_tlb_regs
module tb_cp0_tlb_regs;
  import cp0_tlb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  tlb_typeM = TLB_OP_NONE;
  logic        mtc0_en = 1'b0;
  logic [4:0]  mtc0_addr = '0;
  logic [31:0] mtc0_data = '0;
  logic [4:0]  mfc0_addr = '0;
  logic [31:0] mfc0_data;
  logic        tlbp_found = 1'b0;
  logic [4:0]  tlbp_index = '0;
  logic [31:0] tlbr_EntryHi = '0, tlbr_PageMask = '0, tlbr_EntryLo0 = '0, tlbr_EntryLo1 = '0;
  logic        tlb_exc = 1'b0;
  logic [31:0] tlb_exc_vaddr = '0;
  logic [31:0] EntryHi_o, PageMask_o, EntryLo0_o, EntryLo1_o, Index_o, Random_o;

  int checks = 0;
  int failures = 0;

  cp0_tlb_regs #(.TLB_ENTRIES(32)) dut (
    .clk(clk), .rst(rst), .tlb_typeM(tlb_typeM),
    .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data),
    .tlbp_found(tlbp_found), .tlbp_index(tlbp_index),
    .tlbr_EntryHi(tlbr_EntryHi), .tlbr_PageMask(tlbr_PageMask),
    .tlbr_EntryLo0(tlbr_EntryLo0), .tlbr_EntryLo1(tlbr_EntryLo1),
    .tlb_exc(tlb_exc), .tlb_exc_vaddr(tlb_exc_vaddr),
    .EntryHi_o(EntryHi_o), .PageMask_o(PageMask_o), .EntryLo0_o(EntryLo0_o),
    .EntryLo1_o(EntryLo1_o), .Index_o(Index_o), .Random_o(Random_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_en = 1'b1; mtc0_addr = a; mtc0_data = d;
    tick();
    mtc0_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    mfc0_addr = a;
    #1;
    d = mfc0_data;
  endtask

  logic [31:0] v;

  initial begin
    tick();
    tick();
    check("rst_random", Random_o, 32'd31);
    check("rst_index", Index_o, 32'h0);
    check("rst_entryhi", EntryHi_o, 32'h0);
    check("rst_entrylo0", EntryLo0_o, 32'h0);
    check("rst_entrylo1", EntryLo1_o, 32'h0);
    rd(CP0_WIRED, v); check("rst_wired", v, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 31; i++) tick();
    check("random_at_0", Random_o, 32'd0);
    tick();
    check("random_wrap", Random_o, 32'd31);
    tick();
    check("random_30", Random_o, 32'd30);

    mtc0(CP0_WIRED, 32'd28);
    rd(CP0_WIRED, v); check("wired_rd", v, 32'd28);
    check("wired_reload", Random_o, 32'd31);
    tick(); check("w28_30", Random_o, 32'd30);
    tick(); check("w28_29", Random_o, 32'd29);
    tick(); check("w28_28", Random_o, 32'd28);
    tick(); check("w28_wrap", Random_o, 32'd31);

    mtc0(CP0_ENTRYLO0, 32'hFFFF_FFFF);
    rd(CP0_ENTRYLO0, v); check("mask_entrylo0", v, 32'h03FF_FFFF);
    mtc0(CP0_PAGEMASK, 32'hFFFF_FFFF);
    rd(CP0_PAGEMASK, v); check("mask_pagemask", v, 32'h01FF_E000);
    mtc0(CP0_ENTRYHI, 32'hFFFF_FFFF);
    rd(CP0_ENTRYHI, v); check("mask_entryhi", v, 32'hFFFF_E0FF);
    mtc0(CP0_CONTEXT, 32'hFFFF_FFFF);
    rd(CP0_CONTEXT, v); check("mask_context", v, 32'hFF80_0000);
    mtc0(CP0_INDEX, 32'hFFFF_FFFF);
    check("mask_index", Index_o, 32'h0000_001F);
    rd(5'd7, v); check("unmapped_rd", v, 32'h0);

    tlb_typeM = TLB_OP_TLBP; tlbp_found = 1'b0; tlbp_index = 5'd9;
    tick();
    check("tlbp_miss", Index_o, 32'h8000_0000);
    tlbp_found = 1'b1; tlbp_index = 5'd12;
    tick();
    check("tlbp_hit", Index_o, 32'h0000_000C);

    tlb_typeM = TLB_OP_TLBR; tlbp_found = 1'b0; tlbp_index = '0;
    tlbr_EntryHi = 32'h0000_2000; tlbr_EntryLo0 = 32'h0000_06FB;
    tlbr_PageMask = 32'hFFFF_FFFF; tlbr_EntryLo1 = 32'hFFFF_FFFF;
    tick();
    tlb_typeM = TLB_OP_NONE;
    check("tlbr_entryhi", EntryHi_o, 32'h0000_2000);
    check("tlbr_entrylo0", EntryLo0_o, 32'h0000_06FB);
    check("tlbr_pagemask", PageMask_o, 32'h01FF_E000);
    check("tlbr_entrylo1", EntryLo1_o, 32'h03FF_FFFF);

    tlb_typeM = TLB_OP_TLBWI;
    tick();
    tlb_typeM = TLB_OP_NONE;
    check("tlbwi_noupd", Index_o, 32'h0000_000C);

    mtc0(CP0_ENTRYHI, 32'h0000_0005);
    tlb_exc = 1'b1; tlb_exc_vaddr = 32'h1234_5678;
    mtc0(CP0_ENTRYHI, 32'h0);
    tlb_exc = 1'b0;
    check("exc_entryhi", EntryHi_o, 32'h1234_4005);
    rd(CP0_BADVADDR, v); check("exc_badvaddr", v, 32'h1234_5678);
    rd(CP0_CONTEXT, v); check("exc_context", v, 32'hFF89_1A20);

    mtc0(CP0_WIRED, 32'd31);
    tick(); tick();
    check("wired31_hold", Random_o, 32'd31);

    rst = 1'b1; tlb_typeM = TLB_OP_TLBP; tlbp_found = 1'b1; tlbp_index = 5'd3;
    tick();
    rst = 1'b0; tlb_typeM = TLB_OP_NONE; tlbp_found = 1'b0;
    check("midrst_index", Index_o, 32'h0);
    check("midrst_random", Random_o, 32'd31);
    rd(CP0_BADVADDR, v); check("midrst_badvaddr", v, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_tlb_regs.md
# cp0_tlb_regs

CP0 TLB register file for the MIPS core: it holds Index, Random, EntryLo0/1, Context, PageMask, Wired, BadVAddr and EntryHi. It drives these registers into the TLB as that block's `*_in` operands. It captures the TLB's TLBP/TLBR results and TLB-refill/invalid exception information back into the architectural registers. It sits between the M-stage CP0 access path and the TLB.

## Interface
Parameters:
- `TLB_ENTRIES`, default 32: TLB depth; index/random width is `$clog2(TLB_ENTRIES)` (5).

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `tlb_typeM`  in  3  M-stage TLB op code (none/TLBP/TLBR/TLBWI/TLBWR, shared codes)
- `mtc0_en`  in  1  CP0 write strobe (sel 0)
- `mtc0_addr`  in  5  CP0 register number
- `mtc0_data`  in  32  write data
- `mfc0_addr`  in  5  read register number
- `mfc0_data`  out  32  combinational read of current register value; 0 for unmapped numbers
- `tlbp_found`, `tlbp_index`  in  1 / 5  TLB probe result
- `tlbr_EntryHi`, `tlbr_PageMask`, `tlbr_EntryLo0`, `tlbr_EntryLo1`  in  32 each  TLB read result
- `tlb_exc`  in  1  TLB exception taken in M
- `tlb_exc_vaddr`  in  32  faulting virtual address
- `EntryHi_o`, `PageMask_o`, `EntryLo0_o`, `EntryLo1_o`, `Index_o`, `Random_o`  out  32 each  register values to TLB

## Operation
- Register numbers and writable masks:
  - Index 0: P bit31 and index[4:0]; mtc0 writes index only.
  - Random 1: read-only.
  - EntryLo0 2 / EntryLo1 3: mask 0x03FF_FFFF.
  - Context 4: PTEBase[31:23] writable; BadVPN2[22:4] hardware-only.
  - PageMask 5: mask 0x01FF_E000.
  - Wired 6: [4:0].
  - BadVAddr 8: read-only.
  - EntryHi 10: mask 0xFFFF_E0FF.
- Random: decrements every cycle. When Random == Wired, the next value is 31. Any mtc0 to Wired forces Random to 31 on the next cycle. With Wired = 31, Random holds at 31.
- TLBP: Index <= {~tlbp_found, 26'b0, found ? tlbp_index : 5'b0}.
- TLBR: EntryHi, PageMask, EntryLo0 and EntryLo1 load the `tlbr_*` inputs, each ANDed with its mask.
- TLBWI/TLBWR: no register update. The TLB consumes `Index_o`/`Random_o` in the same cycle.
- tlb_exc: BadVAddr <= vaddr; EntryHi[31:13] <= vaddr[31:13] with ASID kept; Context[22:4] <= vaddr[31:13].
- Priority per register in one cycle: tlb_exc > TLBP/TLBR writeback > mtc0.
- Reset: all registers 0 except Random = 31. Every output therefore resets to 0, except `Random_o` = 31.

## Timing
- All updates take effect at the rising edge. New values are visible on outputs and `mfc0_data` the next cycle; there is no read bypass of same-cycle writes.
- Outputs are registered values, so the TLB sees stable operands for the whole M cycle.
- `rst` mid-operation overrides everything, including pending TLBP/TLBR capture. Random restarts at 31.
- No stall input. The pipeline must hold `tlb_typeM`/`mtc0_en` low when M is stalled or flushed.

## Structure
- Package `cp0_tlb_pkg`:
  - CP0 register number constants.
  - Field masks.
  - TLB op-code enum shared with the TLB.
- Sub-module `tlb_random_ctr`: Random register with Wired compare and Wired-write reload.

## Test plan
- Reset → `Random_o`=31; Index, EntryHi and EntryLo0/1 = 0; `mfc0_data` with addr 6 = 0.
- Counting with Wired=0: 31 cycles after reset, Random=0; the next cycle Random=31. Write Wired=28 → Random runs 31, 30, 29, 28, 31.
- mtc0 0xFFFF_FFFF to EntryLo0/PageMask/EntryHi/Context → reads 0x03FF_FFFF / 0x01FF_E000 / 0xFFFF_E0FF / 0xFF80_0000.
- TLBP with found=0 → Index=0x8000_0000. TLBP with found=1 and index=12 → Index=0x0000_000C.
- TLBR with tlbr_EntryHi=0x0000_2000 and tlbr_EntryLo0=0x0000_06FB → next cycle `EntryHi_o`=0x0000_2000 and `EntryLo0_o`=0x0000_06FB.
- Setup: EntryHi ASID=0x05, Context=0xFF80_0000.
  - Stimulus: tlb_exc with vaddr 0x1234_5678, in the same cycle as mtc0 EntryHi=0.
  - Required response: EntryHi=0x1234_4005, BadVAddr=0x1234_5678, Context=0xFF89_1A20.
